// File: rtl/rf_alu_seq_pkg.sv
// Shared encodings for the rf_alu_seq command sequencer: command types,
// FSM states and NZCV bit positions.
package rf_alu_seq_pkg;

   typedef enum logic [1:0] {
      CMD_LOAD = 2'b00,
      CMD_ALU  = 2'b01,
      CMD_READ = 2'b10,
      CMD_RSVD = 2'b11
   } cmd_type_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_EXEC   = 2'b01,
      ST_VERIFY = 2'b10,
      ST_RESP   = 2'b11
   } state_e;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

endpackage

// File: rtl/rf_alu_seq_if.sv
// Host-side command/response channels of rf_alu_seq; the host is the master.
interface rf_alu_seq_if #(
   parameter int ADDR = 4,
   parameter int SIZE = 32
);
   logic            Cmd_Valid;
   logic            Cmd_Ready;
   logic [1:0]      Cmd_Type;
   logic [3:0]      Cmd_OP;
   logic            Cmd_SCO;
   logic [ADDR-1:0] Cmd_Rs1;
   logic [ADDR-1:0] Cmd_Rs2;
   logic [ADDR-1:0] Cmd_Rd;
   logic [SIZE-1:0] Cmd_Data;
   logic            Rsp_Valid;
   logic            Rsp_Ready;
   logic [SIZE-1:0] Rsp_Data;
   logic [3:0]      Rsp_NZCV;
   logic            Rsp_Err;

   modport master (
      output Cmd_Valid, Cmd_Type, Cmd_OP, Cmd_SCO, Cmd_Rs1, Cmd_Rs2, Cmd_Rd, Cmd_Data, Rsp_Ready,
      input  Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_NZCV, Rsp_Err
   );

   modport slave (
      input  Cmd_Valid, Cmd_Type, Cmd_OP, Cmd_SCO, Cmd_Rs1, Cmd_Rs2, Cmd_Rd, Cmd_Data, Rsp_Ready,
      output Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_NZCV, Rsp_Err
   );
endinterface

// File: rtl/rf_alu_seq_flags.sv
// NZCV flag register; carry and overflow are fed straight back to the ALU.
module rf_alu_seq_flags
   import rf_alu_seq_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       ld_en,
   input  logic [3:0] nzcv_in,
   output logic [3:0] nzcv,
   output logic       cf,
   output logic       vf
);
   logic [3:0] nzcv_d, nzcv_q;

   always_comb begin
      nzcv_d = nzcv_q;
      if (ld_en) nzcv_d = nzcv_in;
   end

   always_ff @(posedge clk) begin
      if (clr) nzcv_q <= 4'b0000;
      else     nzcv_q <= nzcv_d;
   end

   assign nzcv = nzcv_q;
   assign cf   = nzcv_q[NZCV_C];
   assign vf   = nzcv_q[NZCV_V];
endmodule

// File: rtl/rf_alu_seq.sv
// Command sequencer for the register-file + ALU datapath.
// Optional read-back check of LOAD/ALU writes: define RF_ALU_SEQ_VERIFY_EN.
module rf_alu_seq
   import rf_alu_seq_pkg::*;
#(
   parameter int ADDR = 4,
   parameter int SIZE = 32
) (
   input  logic            Clk,
   input  logic            Clr,
   rf_alu_seq_if.slave     bus,
   output logic            Write_Reg,
   output logic            Write_Select,
   output logic [ADDR-1:0] R_Addr_A,
   output logic [ADDR-1:0] R_Addr_B,
   output logic [ADDR-1:0] R_Addr_C,
   output logic [ADDR-1:0] W_Addr,
   output logic [SIZE-1:0] Input_Data,
   output logic [3:0]      OP,
   output logic            SCO,
   output logic            CF,
   output logic            VF,
   input  logic [SIZE-1:0] R_Data_C,
   input  logic [SIZE-1:0] F,
   input  logic            N,
   input  logic            Z,
   input  logic            C,
   input  logic            V
);
   state_e          state_d, state_q;
   cmd_type_e       typ_d, typ_q;
   logic [3:0]      op_d, op_q;
   logic            sco_d, sco_q;
   logic [ADDR-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
   logic [SIZE-1:0] data_d, data_q, res_d, res_q;
   logic            err_d, err_q;
   logic            accept, is_wr;
   logic [3:0]      nzcv;

   assign accept = bus.Cmd_Valid & bus.Cmd_Ready;
   assign is_wr  = (typ_q == CMD_LOAD) || (typ_q == CMD_ALU);

   always_ff @(posedge Clk) begin
      if (Clr) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
`ifdef RF_ALU_SEQ_VERIFY_EN
         ST_EXEC:   state_d = is_wr ? ST_VERIFY : ST_RESP;
         ST_VERIFY: state_d = ST_RESP;
`else
         ST_EXEC:   state_d = ST_RESP;
`endif
         ST_RESP: if (bus.Rsp_Ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Command latch and result capture; the latched fields also drive the
   // datapath, so those outputs hold between commands.
   always_comb begin
      typ_d  = typ_q;
      op_d   = op_q;
      sco_d  = sco_q;
      rs1_d  = rs1_q;
      rs2_d  = rs2_q;
      rd_d   = rd_q;
      data_d = data_q;
      res_d  = res_q;
      err_d  = err_q;
      if (accept) begin
         typ_d  = cmd_type_e'(bus.Cmd_Type);
         op_d   = bus.Cmd_OP;
         sco_d  = bus.Cmd_SCO;
         rs1_d  = bus.Cmd_Rs1;
         rs2_d  = bus.Cmd_Rs2;
         rd_d   = bus.Cmd_Rd;
         data_d = bus.Cmd_Data;
      end
      if (state_q == ST_EXEC) begin
         err_d = 1'b0;
         case (typ_q)
            CMD_LOAD: res_d = data_q;
            CMD_ALU:  res_d = F;
            CMD_READ: res_d = R_Data_C;
            default: begin
               res_d = '0;
               err_d = 1'b1;
            end
         endcase
      end
`ifdef RF_ALU_SEQ_VERIFY_EN
      if (state_q == ST_VERIFY && R_Data_C != res_q) err_d = 1'b1;
`endif
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         typ_q  <= CMD_LOAD;
         op_q   <= '0;
         sco_q  <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
         data_q <= '0;
         res_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         typ_q  <= typ_d;
         op_q   <= op_d;
         sco_q  <= sco_d;
         rs1_q  <= rs1_d;
         rs2_q  <= rs2_d;
         rd_q   <= rd_d;
         data_q <= data_d;
         res_q  <= res_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      bus.Cmd_Ready = (state_q == ST_IDLE) & ~Clr;
      bus.Rsp_Valid = (state_q == ST_RESP);
      bus.Rsp_Data  = res_q;
      bus.Rsp_NZCV  = nzcv;
      bus.Rsp_Err   = err_q;
      Write_Reg     = (state_q == ST_EXEC) & is_wr;
      Write_Select  = (typ_q == CMD_LOAD);
      R_Addr_A      = rs1_q;
      R_Addr_B      = rs2_q;
      R_Addr_C      = rd_q;
      W_Addr        = rd_q;
      Input_Data    = data_q;
      OP            = op_q;
      SCO           = sco_q;
   end

   rf_alu_seq_flags u_flags (
      .clk     (Clk),
      .clr     (Clr),
      .ld_en   ((state_q == ST_EXEC) && (typ_q == CMD_ALU)),
      .nzcv_in ({N, Z, C, V}),
      .nzcv    (nzcv),
      .cf      (CF),
      .vf      (VF)
   );
endmodule

// File: tb/tb_rf_alu_seq.sv
// Directed bench for rf_alu_seq with a small register-file/ALU model and a
// response scoreboard.
module tb_rf_alu_seq;
   localparam int ADDR = 4;
   localparam int SIZE = 32;
`ifdef RF_ALU_SEQ_VERIFY_EN
   localparam int LAT_WR = 3;
`else
   localparam int LAT_WR = 2;
`endif

   typedef struct {
      logic [31:0] d;
      logic [3:0]  nzcv;
      logic        err;
   } exp_t;

   logic            Clk = 1'b0;
   logic            Clr;
   logic            Write_Reg, Write_Select, SCO, CF, VF, N, Z, C, V;
   logic [ADDR-1:0] R_Addr_A, R_Addr_B, R_Addr_C, W_Addr;
   logic [SIZE-1:0] Input_Data, R_Data_C, F;
   logic [3:0]      OP;

   int   errors = 0;
   int   checks = 0;
   int   wr_cnt = 0;
   logic [ADDR-1:0] last_waddr;
   logic last_wsel;
   logic force_bad = 1'b0;
   exp_t exp_q[$];

   always #5 Clk = ~Clk;

   rf_alu_seq_if #(.ADDR(ADDR), .SIZE(SIZE)) bus ();

   rf_alu_seq #(.ADDR(ADDR), .SIZE(SIZE)) dut (
      .Clk(Clk), .Clr(Clr), .bus(bus),
      .Write_Reg(Write_Reg), .Write_Select(Write_Select),
      .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Addr_C(R_Addr_C), .W_Addr(W_Addr),
      .Input_Data(Input_Data), .OP(OP), .SCO(SCO), .CF(CF), .VF(VF),
      .R_Data_C(R_Data_C), .F(F), .N(N), .Z(Z), .C(C), .V(V)
   );

   // Datapath model: OP 0 = add with optional carry-in, otherwise AND.
   logic [SIZE-1:0] rf [16];
   logic [SIZE-1:0] a_v, b_v;
   logic [SIZE:0]   sum;
   assign a_v      = rf[R_Addr_A];
   assign b_v      = rf[R_Addr_B];
   assign sum      = {1'b0, a_v} + {1'b0, b_v} + {{SIZE{1'b0}}, SCO & CF};
   assign F        = (OP == 4'd0) ? sum[SIZE-1:0] : (a_v & b_v);
   assign N        = F[SIZE-1];
   assign Z        = (F == '0);
   assign C        = (OP == 4'd0) & sum[SIZE];
   assign V        = (OP == 4'd0) & (a_v[SIZE-1] == b_v[SIZE-1]) & (sum[SIZE-1] != a_v[SIZE-1]);
   assign R_Data_C = force_bad ? ~rf[R_Addr_C] : rf[R_Addr_C];

   always @(posedge Clk)
      if (Write_Reg) rf[W_Addr] <= Write_Select ? Input_Data : F;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: counts datapath writes and scores every response handshake.
   always @(negedge Clk) begin
      if (Write_Reg === 1'b1) begin
         wr_cnt++;
         last_waddr = W_Addr;
         last_wsel  = Write_Select;
      end
      if (bus.Rsp_Valid === 1'b1 && bus.Rsp_Ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got data %h with empty scoreboard", bus.Rsp_Data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_data", bus.Rsp_Data, e.d);
            chk("rsp_nzcv", {28'd0, bus.Rsp_NZCV}, {28'd0, e.nzcv});
            chk("rsp_err",  {31'd0, bus.Rsp_Err},  {31'd0, e.err});
         end
      end
   end

   // Issue one command and wait until Rsp_Valid; completes the handshake
   // when Rsp_Ready is high.
   task automatic issue(input logic [1:0] typ, input logic [3:0] op, input logic sco,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                        input logic [31:0] data, input logic [31:0] exp_d,
                        input logic [3:0] exp_nzcv, input logic exp_err, input int exp_lat);
      int n;
      int lat;
      exp_t e;
      e.d = exp_d; e.nzcv = exp_nzcv; e.err = exp_err;
      exp_q.push_back(e);
      wr_cnt        = 0;
      bus.Cmd_Type  = typ;
      bus.Cmd_OP    = op;
      bus.Cmd_SCO   = sco;
      bus.Cmd_Rs1   = rs1;
      bus.Cmd_Rs2   = rs2;
      bus.Cmd_Rd    = rd;
      bus.Cmd_Data  = data;
      bus.Cmd_Valid = 1'b1;
      n = 0;
      while (bus.Cmd_Ready !== 1'b1 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL cmd_ready_timeout: got 0 want 1");
      end
      @(posedge Clk);
      #1 bus.Cmd_Valid = 1'b0;
      lat = 0;
      do begin
         @(negedge Clk);
         lat++;
      end while (bus.Rsp_Valid !== 1'b1 && lat < 20);
      chk("rsp_latency", lat, exp_lat);
      if (bus.Rsp_Ready) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = '0;
      Clr = 1'b1;
      bus.Cmd_Valid = 1'b1;
      bus.Cmd_Type  = 2'b00;
      bus.Cmd_OP    = '0;
      bus.Cmd_SCO   = 1'b0;
      bus.Cmd_Rs1   = '0;
      bus.Cmd_Rs2   = '0;
      bus.Cmd_Rd    = 4'd15;
      bus.Cmd_Data  = 32'hDEAD_BEEF;
      bus.Rsp_Ready = 1'b1;

      // Reset: no accept while Clr is high
      repeat (2) begin
         @(negedge Clk);
         chk("rst_cmd_ready_low", {31'd0, bus.Cmd_Ready}, 32'd0);
      end
      @(posedge Clk);
      #1 bus.Cmd_Valid = 1'b0;
      Clr = 1'b0;
      @(negedge Clk);
      chk("rst_cmd_ready", {31'd0, bus.Cmd_Ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.Rsp_Valid}, 32'd0);
      chk("rst_cf_vf",     {30'd0, CF, VF}, 32'd0);
      chk("rst_write_reg", {31'd0, Write_Reg}, 32'd0);
      chk("rst_rsp_data",  bus.Rsp_Data, 32'd0);
      @(posedge Clk);
      #1;

      // LOAD then READ
      issue(2'b00, 4'd0, 1'b0, 4'd0, 4'd0, 4'd3, 32'h1234_5678, 32'h1234_5678, 4'b0000, 1'b0, LAT_WR);
      chk("load_wr_cnt",  wr_cnt, 1);
      chk("load_w_addr",  {28'd0, last_waddr}, 32'd3);
      chk("load_wsel",    {31'd0, last_wsel}, 32'd1);
      issue(2'b10, 4'd0, 1'b0, 4'd0, 4'd0, 4'd3, 32'h0, 32'h1234_5678, 4'b0000, 1'b0, 2);
      chk("read_wr_cnt",  wr_cnt, 0);

      // ALU add with carry out, then carry feedback
      issue(2'b00, 4'd0, 1'b0, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 1'b0, LAT_WR);
      issue(2'b00, 4'd0, 1'b0, 4'd0, 4'd0, 4'd2, 32'h1, 32'h1, 4'b0000, 1'b0, LAT_WR);
      issue(2'b01, 4'd0, 1'b0, 4'd1, 4'd2, 4'd4, 32'h0, 32'h0, 4'b0110, 1'b0, LAT_WR);
      chk("alu_wr_cnt", wr_cnt, 1);
      chk("alu_wsel",   {31'd0, last_wsel}, 32'd0);
      chk("alu_cf",     {31'd0, CF}, 32'd1);
      chk("alu_vf",     {31'd0, VF}, 32'd0);
      issue(2'b10, 4'd0, 1'b0, 4'd0, 4'd0, 4'd4, 32'h0, 32'h0, 4'b0110, 1'b0, 2);
      issue(2'b01, 4'd0, 1'b1, 4'd2, 4'd2, 4'd5, 32'h0, 32'h3, 4'b0000, 1'b0, LAT_WR);
      issue(2'b10, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 4'b0000, 1'b0, 2);

      // Response stall
      bus.Rsp_Ready = 1'b0;
      issue(2'b00, 4'd0, 1'b0, 4'd0, 4'd0, 4'd6, 32'hA5A5_0000, 32'hA5A5_0000, 4'b0000, 1'b0, LAT_WR);
      repeat (5) begin
         @(negedge Clk);
         chk("stall_valid",     {31'd0, bus.Rsp_Valid}, 32'd1);
         chk("stall_data",      bus.Rsp_Data, 32'hA5A5_0000);
         chk("stall_nzcv",      {28'd0, bus.Rsp_NZCV}, 32'd0);
         chk("stall_cmd_ready", {31'd0, bus.Cmd_Ready}, 32'd0);
         chk("stall_write_reg", {31'd0, Write_Reg}, 32'd0);
      end
      @(posedge Clk);
      #1 bus.Rsp_Ready = 1'b1;
      @(posedge Clk);
      #1 chk("stall_release_idle", {31'd0, bus.Cmd_Ready}, 32'd1);

      // Reserved command
      issue(2'b11, 4'd0, 1'b0, 4'd0, 4'd0, 4'd7, 32'hFFFF_0000, 32'h0, 4'b0000, 1'b1, 2);
      chk("rsvd_wr_cnt", wr_cnt, 0);

      // Set carry, then abort an ALU command in EXEC: flags cleared, write kept
      issue(2'b01, 4'd0, 1'b0, 4'd1, 4'd2, 4'd4, 32'h0, 32'h0, 4'b0110, 1'b0, LAT_WR);
      bus.Cmd_Type  = 2'b01;
      bus.Cmd_OP    = 4'd0;
      bus.Cmd_SCO   = 1'b0;
      bus.Cmd_Rs1   = 4'd2;
      bus.Cmd_Rs2   = 4'd2;
      bus.Cmd_Rd    = 4'd9;
      bus.Cmd_Valid = 1'b1;
      @(posedge Clk);
      #1 bus.Cmd_Valid = 1'b0;
      Clr = 1'b1;
      @(posedge Clk);
      #1 Clr = 1'b0;
      repeat (4) begin
         @(negedge Clk);
         chk("abort_no_rsp", {31'd0, bus.Rsp_Valid}, 32'd0);
      end
      chk("abort_idle", {31'd0, bus.Cmd_Ready}, 32'd1);
      chk("abort_cf",   {31'd0, CF}, 32'd0);
      @(posedge Clk);
      #1;
      issue(2'b10, 4'd0, 1'b0, 4'd0, 4'd0, 4'd9, 32'h0, 32'h2, 4'b0000, 1'b0, 2);

`ifdef RF_ALU_SEQ_VERIFY_EN
      // Corrupted read-back during VERIFY flags an error
      force_bad = 1'b1;
      issue(2'b00, 4'd0, 1'b0, 4'd0, 4'd0, 4'd10, 32'h55, 32'h55, 4'b0000, 1'b1, 3);
      force_bad = 1'b0;
`endif

      repeat (3) @(negedge Clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
